// File: rtl/ugemm_ctrl_pkg.sv
// Shared definitions for the array sequencing controller: FSM states and default sizing.
package ugemm_ctrl_pkg;
  localparam int MAC_CYC_DEF = 16;
  localparam int KW_DEF      = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE,
    S_FLUSH
  } state_t;
endpackage

// File: rtl/skew_line.sv
// Shift register exposing every stage; tap i is the input delayed i+1 cycles.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [W-1:0]            d,
  output logic [DEPTH-1:0][W-1:0] taps
);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      taps <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end
endmodule

// File: rtl/array_seq_ctrl.sv
// Job sequencer for a HEIGHT x WIDTH rate-coded MAC array: weight load, skewed compute, skewed drain.
// Optional cycle counter output cyc_cnt when ARRAY_SEQ_CTRL_PERF_EN is defined.
module array_seq_ctrl
  import ugemm_ctrl_pkg::*;
#(
  parameter int HEIGHT  = 4,
  parameter int WIDTH   = 4,
  parameter int MAC_CYC = MAC_CYC_DEF,
  parameter int KW      = KW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [KW-1:0]     k_len,
  output logic              busy,
  output logic              done,
  output logic [HEIGHT-1:0] en_i,
  output logic [HEIGHT-1:0] clr_i,
  output logic [HEIGHT-1:0] mac_done,
  output logic [WIDTH-1:0]  en_w,
  output logic [WIDTH-1:0]  clr_w,
  output logic [WIDTH-1:0]  en_o,
  output logic [WIDTH-1:0]  clr_o,
  output logic [HEIGHT-1:0] ibuf_rd,
  output logic              wbuf_rd,
`ifdef ARRAY_SEQ_CTRL_PERF_EN
  output logic [31:0]       cyc_cnt,
`endif
  output state_t            state
);
  localparam int CW = (MAC_CYC > 1) ? $clog2(MAC_CYC) : 1;
  localparam int SW = $clog2(HEIGHT + WIDTH + 1);

  logic [KW-1:0] k_reg;
  logic [KW-1:0] vec;
  logic [CW-1:0] cyc;
  logic [SW-1:0] step;
  logic          en_i0, clr_i0, mac0, en_o0, clr_o0, en_w_r, clr_w_r, clr_all;
  logic          flush;

  assign flush = abort && (state != S_IDLE);

  // en_i0 doubles as the sub-phase flag inside COMPUTE: high while streaming, low in the skew tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE; busy <= 1'b0; done <= 1'b0;
      k_reg <= '0; vec <= '0; cyc <= '0; step <= '0;
      en_i0 <= 1'b0; clr_i0 <= 1'b0; mac0 <= 1'b0; en_o0 <= 1'b0; clr_o0 <= 1'b0;
      en_w_r <= 1'b0; clr_w_r <= 1'b0; clr_all <= 1'b0;
    end else if (flush) begin
      state <= S_FLUSH; busy <= 1'b1; done <= 1'b0;
      vec <= '0; cyc <= '0; step <= '0;
      en_i0 <= 1'b0; clr_i0 <= 1'b0; mac0 <= 1'b0; en_o0 <= 1'b0; clr_o0 <= 1'b0;
      en_w_r <= 1'b0; clr_w_r <= 1'b0; clr_all <= 1'b1;
    end else begin
      clr_all <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            k_reg <= k_len; busy <= 1'b1;
            vec <= '0; cyc <= '0; step <= '0;
            if (k_len == '0) begin
              state <= S_DONE; done <= 1'b1;
            end else begin
              state <= S_WLOAD; clr_w_r <= 1'b1;
            end
          end
        end
        S_WLOAD: begin
          clr_w_r <= 1'b0;
          if (step == SW'(HEIGHT)) begin
            state <= S_COMPUTE; en_w_r <= 1'b0;
            en_i0 <= 1'b1; clr_i0 <= 1'b1; mac0 <= 1'b0;
            cyc <= '0; vec <= '0; step <= '0;
          end else begin
            en_w_r <= 1'b1; step <= step + 1'b1;
          end
        end
        S_COMPUTE: begin
          clr_i0 <= 1'b0;
          if (en_i0) begin
            if (cyc == CW'(MAC_CYC - 1)) begin
              cyc <= '0; mac0 <= 1'b0;
              if (vec == k_reg - KW'(1)) begin
                en_i0 <= 1'b0; vec <= '0; step <= '0;
                if (HEIGHT == 1) begin
                  state <= S_DRAIN; en_o0 <= 1'b1;
                end
              end else begin
                vec <= vec + 1'b1;
              end
            end else begin
              cyc  <= cyc + 1'b1;
              mac0 <= (cyc == CW'(MAC_CYC - 2));
            end
          end else if (step == SW'(HEIGHT - 2)) begin
            state <= S_DRAIN; en_o0 <= 1'b1; step <= '0;
          end else begin
            step <= step + 1'b1;
          end
        end
        S_DRAIN: begin
          if (step == SW'(HEIGHT + WIDTH - 1)) begin
            state <= S_DONE; done <= 1'b1;
            en_o0 <= 1'b0; clr_o0 <= 1'b0; step <= '0;
          end else begin
            step   <= step + 1'b1;
            en_o0  <= (step + SW'(1)) <  SW'(HEIGHT);
            clr_o0 <= (step + SW'(1)) == SW'(HEIGHT);
          end
        end
        S_DONE: begin
          state <= S_IDLE; done <= 1'b0; busy <= 1'b0;
        end
        S_FLUSH: begin
          state <= S_IDLE; busy <= 1'b0;
        end
        default: begin
          state <= S_IDLE; busy <= 1'b0; done <= 1'b0;
        end
      endcase
    end
  end

  // Row h and column w replay the edge-0 sequence delayed h (resp. w) cycles.
  logic [HEIGHT-1:0][2:0] row_bus;
  logic [WIDTH-1:0][1:0]  col_bus;
  assign row_bus[0] = {mac0, clr_i0, en_i0};
  assign col_bus[0] = {clr_o0, en_o0};

  if (HEIGHT > 1) begin : g_row_skew
    skew_line #(.DEPTH(HEIGHT - 1), .W(3)) u_row (
      .clk(clk), .rst(rst), .flush(flush), .d(row_bus[0]), .taps(row_bus[HEIGHT-1:1])
    );
  end
  if (WIDTH > 1) begin : g_col_skew
    skew_line #(.DEPTH(WIDTH - 1), .W(2)) u_col (
      .clk(clk), .rst(rst), .flush(flush), .d(col_bus[0]), .taps(col_bus[WIDTH-1:1])
    );
  end

  always_comb begin
    for (int h = 0; h < HEIGHT; h++) begin
      en_i[h]     = row_bus[h][0];
      clr_i[h]    = row_bus[h][1] | clr_all;
      mac_done[h] = row_bus[h][2];
    end
    for (int w = 0; w < WIDTH; w++) begin
      en_o[w]  = col_bus[w][0];
      clr_o[w] = col_bus[w][1] | clr_all;
    end
  end

  assign en_w    = {WIDTH{en_w_r}};
  assign clr_w   = {WIDTH{clr_w_r | clr_all}};
  assign ibuf_rd = en_i;
  assign wbuf_rd = en_w_r;

`ifdef ARRAY_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if (state == S_IDLE && start && !abort) begin
      cyc_cnt <= '0;
    end else if (busy && cyc_cnt != '1) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_array_seq_ctrl.sv
// Scoreboarded bench for array_seq_ctrl: per-cycle expected output words from a timing-rule model.
module tb_array_seq_ctrl;
  import ugemm_ctrl_pkg::*;

  localparam int H  = 4;
  localparam int W  = 4;
  localparam int M  = 16;
  localparam int KW = 8;
  localparam int OW = 3 + 4*H + 4*W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          busy, done, wbuf_rd;
  logic [H-1:0]  en_i, clr_i, mac_done, ibuf_rd;
  logic [W-1:0]  en_w, clr_w, en_o, clr_o;
  state_t        state;
`ifdef ARRAY_SEQ_CTRL_PERF_EN
  logic [31:0]   cyc_cnt;
`endif

  array_seq_ctrl #(.HEIGHT(H), .WIDTH(W), .MAC_CYC(M), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .k_len(k_len),
    .busy(busy), .done(done),
    .en_i(en_i), .clr_i(clr_i), .mac_done(mac_done),
    .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o),
    .ibuf_rd(ibuf_rd), .wbuf_rd(wbuf_rd),
`ifdef ARRAY_SEQ_CTRL_PERF_EN
    .cyc_cnt(cyc_cnt),
`endif
    .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc_now = 0;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            exp_cnt_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic int job_len(input int k);
    return (k == 0) ? 1 : k*M + 3*H + W + 1;
  endfunction

  // Expected outputs t cycles after the start cycle, from the job timing rules.
  function automatic logic [OW-1:0] model(input int k, input int t, input int ab, input int rs);
    logic b_e, d_e;
    logic [H-1:0] ei, ci, md;
    logic [W-1:0] ew, cw, eo, co;
    int l, base, c0;
    b_e = 1'b0; d_e = 1'b0;
    ei = '0; ci = '0; md = '0; ew = '0; cw = '0; eo = '0; co = '0;
    l = job_len(k);
    if (rs >= 0 && t > rs) begin
      b_e = 1'b0;
    end else if (ab >= 0 && t > ab) begin
      if (t == ab + 1) begin
        b_e = 1'b1; ci = '1; cw = '1; co = '1;
      end
    end else begin
      b_e = (t >= 1 && t <= l);
      d_e = (t == l);
      if (k > 0) begin
        cw = {W{t == 1}};
        ew = {W{t >= 2 && t <= H + 1}};
        for (int h = 0; h < H; h++) begin
          base  = H + 2 + h;
          ei[h] = (t >= base && t < base + k*M);
          ci[h] = (t == base);
          md[h] = ei[h] && ((t - base) % M == M - 1);
        end
        c0 = k*M + 2*H + 1;
        for (int w = 0; w < W; w++) begin
          eo[w] = (t >= c0 + w && t < c0 + w + H);
          co[w] = (t == c0 + w + H);
        end
      end
    end
    return {~b_e, b_e, d_e, ei, ci, md, ei, ew, cw, eo, co, ew[0]};
  endfunction

  function automatic int cnt_model(input int k, input int t, input int ab, input int rs);
    int last;
    if (rs >= 0 && t > rs) return 0;
    last = (ab >= 0) ? ab + 1 : job_len(k);
    return (t - 1 < last) ? t - 1 : last;
  endfunction

  function automatic logic [OW-1:0] idle_word();
    logic [OW-1:0] v;
    v = '0;
    v[OW-1] = 1'b1;
    return v;
  endfunction

  task automatic push_exp(input int c, input logic [OW-1:0] v, input int cnt);
    exp_cyc_q.push_back(c);
    exp_q.push_back(v);
    exp_cnt_q.push_back(cnt);
  endtask

  // monitor
  logic [OW-1:0] dut_w, e_w;
  int            e_c, e_cnt;
  assign dut_w = {state == S_IDLE, busy, done, en_i, clr_i, mac_done, ibuf_rd,
                  en_w, clr_w, en_o, clr_o, wbuf_rd};

  always @(negedge clk) begin
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc_now) begin
      e_c = exp_cyc_q.pop_front();
      e_w = exp_q.pop_front();
      e_cnt = exp_cnt_q.pop_front();
      n_cmp++;
      if (e_c != cyc_now || dut_w !== e_w) begin
        n_err++;
        $display("FAIL out_word cyc=%0d (exp for %0d) got=%h want=%h", cyc_now, e_c, dut_w, e_w);
      end
`ifdef ARRAY_SEQ_CTRL_PERF_EN
      if (e_cnt >= 0) begin
        n_cmp++;
        if (cyc_cnt !== 32'(e_cnt)) begin
          n_err++;
          $display("FAIL cyc_cnt cyc=%0d got=%0d want=%0d", cyc_now, cyc_cnt, e_cnt);
        end
      end
`endif
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic job(input int k, input int ab, input int rs, input int tail);
    int l, last_busy, tend, c0;
    l = job_len(k);
    last_busy = l;
    if (ab >= 0 && ab + 1 < last_busy) last_busy = ab + 1;
    if (rs >= 0 && rs < last_busy) last_busy = rs;
    tend = (rs >= 0) ? rs + 2 : (ab >= 0) ? ab + 3 : l + tail;
    c0 = cyc_now;
    for (int t = 1; t <= tend; t++) push_exp(c0 + t, model(k, t, ab, rs), cnt_model(k, t, ab, rs));
    for (int t = 0; t < tend; t++) begin
      start = (t == 0) || (t <= last_busy && $urandom_range(0, 3) == 0);
      k_len = (t == 0) ? KW'(k) : KW'($urandom);
      abort = (t == ab);
      rst   = (t == rs);
      step();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  int k_r, ab_r, rs_r, l_r;

  initial begin
    rst = 1'b1;
    step(); step();
    push_exp(cyc_now, idle_word(), -1);
    push_exp(cyc_now + 1, idle_word(), -1);
    rst = 1'b0;
    step();

    job(2, -1, -1, 11);          // reference job: done at +49, counter held while idle
    job(0, -1, -1, 3);           // empty job
    job(2, 20, -1, 0);           // abort mid-compute
    job(2, -1, 30, 0);           // reset mid-compute
    job(2, -1, -1, 2);           // full job after reset
    job(1, job_len(1), -1, 0);   // abort in the DONE cycle

    // abort and start together while idle: nothing starts
    start = 1'b1; abort = 1'b1; k_len = KW'(2);
    for (int i = 1; i <= 3; i++) push_exp(cyc_now + i, idle_word(), -1);
    step();
    start = 1'b0; abort = 1'b0;
    step(); step();

    for (int n = 0; n < 10; n++) begin
      k_r = $urandom_range(0, 3);
      l_r = job_len(k_r);
      ab_r = -1; rs_r = -1;
      case ($urandom_range(0, 3))
        0: ab_r = $urandom_range(1, l_r);
        1: if (l_r > 1) rs_r = $urandom_range(1, l_r - 1);
        default: ;
      endcase
      job(k_r, ab_r, rs_r, $urandom_range(1, 4));
    end

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
